// File: rtl/bbox_scanner_if.sv
// Pixel RAM read bus between bbox_scanner (master) and the pixel RAM (slave).
// rd_data is expected one cycle after the cycle rd_en is high.
interface bbox_scanner_if #(
  parameter int ADDR_W = 15
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/bbox_scanner.sv
// Raster-scans a pixel RAM and reports the bounding box of pixels >= threshold.
// Optional macro BBOX_PIXEL_COUNT_EN adds a 16-bit qualifying-pixel count output.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last results
// READ  | issuing one pixel address per cycle
// DRAIN | last pixel arriving; results loaded into the output registers
// DONE  | done pulse, final results visible
module bbox_scanner #(
  parameter int IMG_W  = 100,
  parameter int IMG_H  = 100,
  parameter int ADDR_W = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            threshold,
  bbox_scanner_if.master        ram,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [7:0]            x_min,
  output logic [7:0]            x_max,
  output logic [7:0]            y_min,
  output logic [7:0]            y_max
`ifdef BBOX_PIXEL_COUNT_EN
  ,
  output logic [15:0]           pixel_count
`endif
);

  localparam int          NPIX     = IMG_W * IMG_H;
  localparam logic [15:0] LAST_CNT = 16'(NPIX - 1);
  localparam logic [7:0]  X_LAST   = 8'(IMG_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [15:0]       remain_q, remain_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        x_q, x_d, y_q, y_d;
  logic [7:0]        thr_q, thr_d;
  logic              pix_vld_q, pix_vld_d;
  logic [7:0]        pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic              any_q, any_d;
  logic [7:0]        xmin_acc_q, xmin_acc_d, xmax_acc_q, xmax_acc_d;
  logic [7:0]        ymin_acc_q, ymin_acc_d, ymax_acc_q, ymax_acc_d;
  logic              found_q, found_d;
  logic [7:0]        x_min_q, x_min_d, x_max_q, x_max_d;
  logic [7:0]        y_min_q, y_min_d, y_max_q, y_max_d;
`ifdef BBOX_PIXEL_COUNT_EN
  logic [15:0]       cnt_acc_q, cnt_acc_d;
  logic [15:0]       pixel_count_q, pixel_count_d;
`endif

  logic rd_en;
  logic start_acc;
  logic tc;
  logic qual;

  assign start_acc = (state_q == S_IDLE) && start;
  assign tc        = (remain_q == 16'd0);
  assign qual      = pix_vld_q && (ram.rd_data >= thr_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_READ;
      S_READ:  if (tc)    state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en = (state_q == S_READ);
    busy  = (state_q == S_READ) || (state_q == S_DRAIN);
    done  = (state_q == S_DONE);
  end

  assign ram.rd_en   = rd_en;
  assign ram.rd_addr = addr_q;

  // Down-counter of remaining addresses ends the read phase; x/y follow the issued address.
  always_comb begin
    remain_d = remain_q;
    addr_d   = addr_q;
    x_d      = x_q;
    y_d      = y_q;
    thr_d    = thr_q;
    if (start_acc) begin
      remain_d = LAST_CNT;
      addr_d   = '0;
      x_d      = 8'd0;
      y_d      = 8'd0;
      thr_d    = threshold;
    end else if (state_q == S_READ) begin
      if (tc) begin
        addr_d = '0;
      end else begin
        remain_d = remain_q - 16'd1;
        addr_d   = addr_q + ADDR_W'(1);
      end
      if (x_q == X_LAST) begin
        x_d = 8'd0;
        y_d = y_q + 8'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
    end
  end

  always_comb begin
    pix_vld_d = rd_en;
    pix_x_d   = x_q;
    pix_y_d   = y_q;
  end

  always_comb begin
    any_d      = any_q;
    xmin_acc_d = xmin_acc_q;
    xmax_acc_d = xmax_acc_q;
    ymin_acc_d = ymin_acc_q;
    ymax_acc_d = ymax_acc_q;
`ifdef BBOX_PIXEL_COUNT_EN
    cnt_acc_d  = cnt_acc_q;
`endif
    if (start_acc) begin
      any_d      = 1'b0;
      xmin_acc_d = 8'hFF;
      xmax_acc_d = 8'h00;
      ymin_acc_d = 8'hFF;
      ymax_acc_d = 8'h00;
`ifdef BBOX_PIXEL_COUNT_EN
      cnt_acc_d  = 16'd0;
`endif
    end else if (qual) begin
      any_d = 1'b1;
      if (pix_x_q < xmin_acc_q) xmin_acc_d = pix_x_q;
      if (pix_x_q > xmax_acc_q) xmax_acc_d = pix_x_q;
      if (pix_y_q < ymin_acc_q) ymin_acc_d = pix_y_q;
      if (pix_y_q > ymax_acc_q) ymax_acc_d = pix_y_q;
`ifdef BBOX_PIXEL_COUNT_EN
      cnt_acc_d = cnt_acc_q + 16'd1;
`endif
    end
  end

  // Results take the accumulator next-values so the last pixel (arriving in DRAIN) is included.
  always_comb begin
    found_d = found_q;
    x_min_d = x_min_q;
    x_max_d = x_max_q;
    y_min_d = y_min_q;
    y_max_d = y_max_q;
`ifdef BBOX_PIXEL_COUNT_EN
    pixel_count_d = pixel_count_q;
`endif
    if (state_q == S_DRAIN) begin
      found_d = any_d;
      x_min_d = any_d ? xmin_acc_d : 8'd0;
      x_max_d = any_d ? xmax_acc_d : 8'd0;
      y_min_d = any_d ? ymin_acc_d : 8'd0;
      y_max_d = any_d ? ymax_acc_d : 8'd0;
`ifdef BBOX_PIXEL_COUNT_EN
      pixel_count_d = cnt_acc_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remain_q   <= 16'd0;
      addr_q     <= '0;
      x_q        <= 8'd0;
      y_q        <= 8'd0;
      thr_q      <= 8'd0;
      pix_vld_q  <= 1'b0;
      pix_x_q    <= 8'd0;
      pix_y_q    <= 8'd0;
      any_q      <= 1'b0;
      xmin_acc_q <= 8'hFF;
      xmax_acc_q <= 8'h00;
      ymin_acc_q <= 8'hFF;
      ymax_acc_q <= 8'h00;
      found_q    <= 1'b0;
      x_min_q    <= 8'd0;
      x_max_q    <= 8'd0;
      y_min_q    <= 8'd0;
      y_max_q    <= 8'd0;
`ifdef BBOX_PIXEL_COUNT_EN
      cnt_acc_q     <= 16'd0;
      pixel_count_q <= 16'd0;
`endif
    end else begin
      remain_q   <= remain_d;
      addr_q     <= addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      thr_q      <= thr_d;
      pix_vld_q  <= pix_vld_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
      any_q      <= any_d;
      xmin_acc_q <= xmin_acc_d;
      xmax_acc_q <= xmax_acc_d;
      ymin_acc_q <= ymin_acc_d;
      ymax_acc_q <= ymax_acc_d;
      found_q    <= found_d;
      x_min_q    <= x_min_d;
      x_max_q    <= x_max_d;
      y_min_q    <= y_min_d;
      y_max_q    <= y_max_d;
`ifdef BBOX_PIXEL_COUNT_EN
      cnt_acc_q     <= cnt_acc_d;
      pixel_count_q <= pixel_count_d;
`endif
    end
  end

  assign found = found_q;
  assign x_min = x_min_q;
  assign x_max = x_max_q;
  assign y_min = y_min_q;
  assign y_max = y_max_q;
`ifdef BBOX_PIXEL_COUNT_EN
  assign pixel_count = pixel_count_q;
`endif

endmodule
